// File: rtl/ntt_pkg.sv
// Shared types for the NTT operand fetch path: FSM state, operand bundle, size helpers.
package ntt_pkg;

    localparam int unsigned KMax         = 64;
    localparam int unsigned LogNMax      = 16;
    localparam int unsigned SwMax        = 4;
    localparam int unsigned LogNDefault  = 8;
    localparam int unsigned NDefault     = 1 << LogNDefault;
    localparam int unsigned HalfNDefault = NDefault / 2;

    typedef enum logic [2:0] {
        StIdle      = 3'd0,
        StIssue     = 3'd1,
        StFlush     = 3'd2,
        StWaitDrain = 3'd3,
        StDone      = 3'd4
    } fetch_state_t;

    // Fields are sized for the largest supported build; users take the low bits.
    typedef struct packed {
        logic [KMax-1:0]    a;
        logic [KMax-1:0]    b;
        logic [LogNMax-1:0] tw_idx;
        logic [SwMax-1:0]   stage;
        logic [LogNMax-1:0] addr_a;
        logic [LogNMax-1:0] addr_b;
    } bundle_t;

    function automatic int unsigned ntt_n(input int unsigned log_n);
        return 32'd1 << log_n;
    endfunction

    function automatic int unsigned ntt_half_n(input int unsigned log_n);
        return ntt_n(log_n) >> 1;
    endfunction

endpackage

// File: rtl/ntt_fetch_skid.sv
// Two-entry FIFO of operand bundles; head is registered and drives the stream outputs.
module ntt_fetch_skid
    import ntt_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       push_i,
    input  bundle_t    data_i,
    input  logic       pop_i,
    output bundle_t    head_o,
    output logic [1:0] count_o
);

    bundle_t    mem_q [2];
    logic       wr_ptr_q;
    logic       rd_ptr_q;
    logic [1:0] count_q;
    logic       do_push;
    logic       do_pop;

    assign do_pop  = pop_i && (count_q != 2'd0);
    assign do_push = push_i && ((count_q != 2'd2) || do_pop);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/ntt_operand_fetch.sv
// Cooley-Tukey operand sequencer: paired RAM reads per butterfly, skid-buffered output stream,
// per-stage drain barrier. Optional input range checking under NTT_RANGE_CHECK_EN.
module ntt_operand_fetch
    import ntt_pkg::*;
#(
    parameter int unsigned K     = 32,
    parameter int unsigned LOG_N = LogNDefault,
    parameter int unsigned SW    = (LOG_N > 1) ? $clog2(LOG_N) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [K-1:0]     mod_in,
    output logic             busy,
    output logic             done,
    output logic             ram_rd_en,
    output logic [LOG_N-1:0] ram_addr_a,
    output logic [LOG_N-1:0] ram_addr_b,
    input  logic [K-1:0]     ram_rdata_a,
    input  logic [K-1:0]     ram_rdata_b,
    input  logic             drain,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [K-1:0]     a,
    output logic [K-1:0]     b,
    output logic [K-1:0]     mod,
    output logic [LOG_N-1:0] tw_idx,
    output logic [SW-1:0]    out_stage,
    output logic [LOG_N-1:0] out_addr_a,
    output logic [LOG_N-1:0] out_addr_b,
    output logic             range_err
);

    localparam int unsigned HalfN = ntt_half_n(LOG_N);
    localparam logic [LOG_N-1:0] LastK = LOG_N'(HalfN - 1);
    localparam logic [SW-1:0]    LastS = SW'(LOG_N - 1);

    fetch_state_t     state_q, state_d;
    logic [SW-1:0]    s_q, s_d;
    logic [LOG_N-1:0] k_q, k_d;
    logic [K-1:0]     mod_q, mod_d;
    logic             inflight_q;
    logic [LOG_N-1:0] tag_addr_a_q, tag_addr_b_q, tag_tw_q;
    logic [SW-1:0]    tag_stage_q;

    logic [SW-1:0]    hshift;
    logic [LOG_N-1:0] h, g, o;
    logic [LOG_N-1:0] gen_addr_a, gen_addr_b, gen_tw;
    logic             issue, pop;
    logic [1:0]       count;
    bundle_t          push_data, head;
    logic             unused_head;

    // h is the butterfly span; g selects the block, o the offset inside it.
    always_comb begin
        hshift     = LastS - s_q;
        h          = LOG_N'(1) << hshift;
        g          = k_q >> hshift;
        o          = k_q & (h - LOG_N'(1));
        gen_addr_a = ((g << hshift) << 1) + o;
        gen_addr_b = gen_addr_a + h;
        gen_tw     = (LOG_N'(1) << s_q) + g;
    end

    assign out_valid = (count != 2'd0);
    assign pop       = out_valid && out_ready;
    assign issue     = (state_q == StIssue)
                       && ((({1'b0, count} + {2'b00, inflight_q}) < 3'd2) || pop);

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        k_d     = k_q;
        mod_d   = mod_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    mod_d   = mod_in;
                    s_d     = '0;
                    k_d     = '0;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (issue) begin
                    k_d = k_q + LOG_N'(1);
                    if (k_q == LastK) state_d = StFlush;
                end
            end
            StFlush: begin
                if ((count == 2'd0) && !inflight_q) state_d = StWaitDrain;
            end
            StWaitDrain: begin
                if (drain) begin
                    if (s_q == LastS) begin
                        state_d = StDone;
                    end else begin
                        s_d     = s_q + SW'(1);
                        k_d     = '0;
                        state_d = StIssue;
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            s_q          <= '0;
            k_q          <= '0;
            mod_q        <= '0;
            inflight_q   <= 1'b0;
            tag_addr_a_q <= '0;
            tag_addr_b_q <= '0;
            tag_tw_q     <= '0;
            tag_stage_q  <= '0;
        end else begin
            state_q    <= state_d;
            s_q        <= s_d;
            k_q        <= k_d;
            mod_q      <= mod_d;
            inflight_q <= issue;
            if (issue) begin
                tag_addr_a_q <= gen_addr_a;
                tag_addr_b_q <= gen_addr_b;
                tag_tw_q     <= gen_tw;
                tag_stage_q  <= s_q;
            end
        end
    end

    always_comb begin
        push_data        = '0;
        push_data.a      = KMax'(ram_rdata_a);
        push_data.b      = KMax'(ram_rdata_b);
        push_data.tw_idx = LogNMax'(tag_tw_q);
        push_data.stage  = SwMax'(tag_stage_q);
        push_data.addr_a = LogNMax'(tag_addr_a_q);
        push_data.addr_b = LogNMax'(tag_addr_b_q);
    end

    ntt_fetch_skid u_skid (
        .clk_i   (clk),
        .rst_i   (rst),
        .push_i  (inflight_q),
        .data_i  (push_data),
        .pop_i   (pop),
        .head_o  (head),
        .count_o (count)
    );

    assign busy       = (state_q != StIdle) && (state_q != StDone);
    assign done       = (state_q == StDone);
    assign ram_rd_en  = issue;
    assign ram_addr_a = issue ? gen_addr_a : '0;
    assign ram_addr_b = issue ? gen_addr_b : '0;
    assign mod        = mod_q;
    assign a          = head.a[K-1:0];
    assign b          = head.b[K-1:0];
    assign tw_idx     = head.tw_idx[LOG_N-1:0];
    assign out_stage  = head.stage[SW-1:0];
    assign out_addr_a = head.addr_a[LOG_N-1:0];
    assign out_addr_b = head.addr_b[LOG_N-1:0];
    assign unused_head = ^head;

`ifdef NTT_RANGE_CHECK_EN
    logic range_err_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            range_err_q <= 1'b0;
        end else if ((state_q == StIdle) && start) begin
            range_err_q <= 1'b0;
        end else if (inflight_q && ((ram_rdata_a >= mod_q) || (ram_rdata_b >= mod_q))) begin
            range_err_q <= 1'b1;
        end
    end

    assign range_err = range_err_q;
`else
    assign range_err = 1'b0;
`endif

endmodule

// File: tb/tb_ntt_operand_fetch.sv
// Scoreboard bench for ntt_operand_fetch with LOG_N=3 and a behavioural butterfly-order model.
module tb_ntt_operand_fetch;

    localparam int K     = 8;
    localparam int LOG_N = 3;
    localparam int N     = 1 << LOG_N;
    localparam int SW    = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [K-1:0]     mod_in;
    logic             busy, done, ram_rd_en, out_valid, out_ready, drain, range_err;
    logic [LOG_N-1:0] ram_addr_a, ram_addr_b, tw_idx, out_addr_a, out_addr_b;
    logic [K-1:0]     ram_rdata_a, ram_rdata_b, a, b, mod;
    logic [SW-1:0]    out_stage;

    typedef struct {
        int a;
        int b;
        int tw;
        int stage;
        int aa;
        int ab;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   ram_mode = 0;
    int   cur_mod = 0;
    bit   viol = 0;
    int   xfers = 0;
    int   dones = 0;
    int   outstanding = 0;
    bit   rand_ready = 0;
    bit   ready_fixed = 1;

    always #5 clk = ~clk;

    ntt_operand_fetch #(.K(K), .LOG_N(LOG_N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .mod_in      (mod_in),
        .busy        (busy),
        .done        (done),
        .ram_rd_en   (ram_rd_en),
        .ram_addr_a  (ram_addr_a),
        .ram_addr_b  (ram_addr_b),
        .ram_rdata_a (ram_rdata_a),
        .ram_rdata_b (ram_rdata_b),
        .drain       (drain),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .a           (a),
        .b           (b),
        .mod         (mod),
        .tw_idx      (tw_idx),
        .out_stage   (out_stage),
        .out_addr_a  (out_addr_a),
        .out_addr_b  (out_addr_b),
        .range_err   (range_err)
    );

    function automatic int ram_val(input int addr);
        if (ram_mode == 0) return addr + 100;
        return (addr == 5) ? 17 : addr;
    endfunction

    always @(posedge clk) begin
        if (ram_rd_en) begin
            ram_rdata_a <= K'(ram_val(int'(ram_addr_a)));
            ram_rdata_b <= K'(ram_val(int'(ram_addr_b)));
        end
    end

    task automatic check(input string name, input longint act, input longint req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Reference order: per stage, blocks of span 2h, each with h butterflies.
    task automatic push_run(input int m);
        exp_t e;
        viol = 0;
        for (int s = 0; s < LOG_N; s++) begin
            int h = 1 << (LOG_N - 1 - s);
            for (int blk = 0; blk < N / (2 * h); blk++) begin
                for (int o = 0; o < h; o++) begin
                    e.aa    = blk * 2 * h + o;
                    e.ab    = e.aa + h;
                    e.tw    = (1 << s) + blk;
                    e.stage = s;
                    e.a     = ram_val(e.aa);
                    e.b     = ram_val(e.ab);
                    if (e.a >= m || e.b >= m) viol = 1;
                    expq.push_back(e);
                end
            end
        end
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Monitor: head must always match the scoreboard front; transfers pop it.
    always @(negedge clk) begin
        if (rst) begin
            outstanding = 0;
        end else begin
            if (ram_rd_en && !(out_valid && out_ready)) check("issue_window", outstanding < 2, 1);
            if (ram_rd_en) outstanding++;
            if (done) dones++;
            if (out_valid) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_bundle actual=addr_a %0d required=none", out_addr_a);
                end else begin
                    check("a", a, expq[0].a);
                    check("b", b, expq[0].b);
                    check("tw_idx", tw_idx, expq[0].tw);
                    check("stage", out_stage, expq[0].stage);
                    check("addr_a", out_addr_a, expq[0].aa);
                    check("addr_b", out_addr_b, expq[0].ab);
                    check("mod", mod, cur_mod);
                    if (out_ready) begin
                        void'(expq.pop_front());
                        xfers++;
                        outstanding--;
                    end
                end
            end
        end
    end

    task automatic do_start(input int m);
        xfers = 0;
        dones = 0;
        @(posedge clk);
        #1;
        start   = 1'b1;
        mod_in  = K'(m);
        cur_mod = m;
        push_run(m);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        check("range_err_cleared", range_err, 0);
    endtask

    task automatic wait_done(input string name);
        int  c = 0;
        bit  req_err;
        while (dones == 0 && c < 3000) begin
            @(negedge clk);
            c++;
        end
        check({name, "_no_timeout"}, dones > 0, 1);
        repeat (4) @(negedge clk);
`ifdef NTT_RANGE_CHECK_EN
        req_err = viol;
`else
        req_err = 1'b0;
`endif
        check({name, "_done_pulses"}, dones, 1);
        check({name, "_transfers"}, xfers, 12);
        check({name, "_queue_empty"}, expq.size(), 0);
        check({name, "_busy_low"}, busy, 0);
        check({name, "_range_err"}, range_err, req_err);
    endtask

    initial begin
        int c;
        bit seen;
        rst         = 1'b1;
        start       = 1'b0;
        mod_in      = '0;
        drain       = 1'b1;
        out_ready   = 1'b1;
        ram_rdata_a = '0;
        ram_rdata_b = '0;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rd_en", ram_rd_en, 0);
        check("rst_valid", out_valid, 0);
        check("rst_mod", mod, 0);
        check("rst_a", a, 0);
        check("rst_tw", tw_idx, 0);
        check("rst_stage", out_stage, 0);
        check("rst_out_addr_b", out_addr_b, 0);
        check("rst_ram_addr_b", ram_addr_b, 0);
        check("rst_range_err", range_err, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Full-rate run.
        do_start(17);
        wait_done("full_rate");

        // Random backpressure with a start pulse while busy.
        rand_ready = 1;
        do_start(200);
        repeat (6) @(posedge clk);
        #1;
        start  = 1'b1;
        mod_in = 8'd33;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done("random_ready");

        // Drain barrier after stage 0.
        drain = 1'b0;
        do_start(150);
        c = 0;
        while (xfers < 4 && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("stage0_reached", xfers, 4);
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (ram_rd_en || !busy) seen = 1;
        end
        check("barrier_held", seen, 0);
        check("barrier_xfers", xfers, 4);
        drain = 1'b1;
        wait_done("drain_barrier");

        // Reset in the middle of stage 1 while a bundle is presented.
        do_start(120);
        c = 0;
        while (!(xfers >= 5 && xfers < 8 && out_valid) && c < 500) begin
            @(negedge clk);
            c++;
        end
        check("mid_stage1_found", (xfers >= 5 && xfers < 8 && out_valid), 1);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", out_valid, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rd_en", ram_rd_en, 0);
        expq.delete();
        repeat (2) @(negedge clk);
        check("mid_rst_no_done", dones, 0);
        #2;
        rst = 1'b0;
        do_start(130);
        wait_done("after_reset");

        // Range check: address 5 holds 17 == mod, then a clean run clears it.
        rand_ready = 0;
        ram_mode   = 1;
        do_start(17);
        wait_done("range_hit");
        ram_mode = 0;
        do_start(200);
        wait_done("range_clean");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ntt_operand_fetch.md
Name: ntt_operand_fetch

Overview:
- Upstream operand sequencer for the NTT butterfly datapath (mod_addition / mod_subtraction / twiddle multiply).
- On start, walks all LOG_N Cooley-Tukey stages and issues paired reads to a dual-read coefficient RAM.
- Presents (a, b, mod, twiddle index, writeback addresses) on a valid/ready stream through a 2-entry skid buffer.
- Enforces a per-stage barrier until downstream writeback drains.

Parameters:
- K, `K (params.vh): coefficient/modulus width.
- LOG_N, 8: log2 of transform length; N = 2**LOG_N.
- SW, $clog2(LOG_N) (minimum 1): stage-counter width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- start  in  1  one-cycle pulse; ignored while busy
- mod_in  in  K  modulus, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after final stage drains
- ram_rd_en  out  1  read strobe; data returns exactly 1 cycle later
- ram_addr_a  out  LOG_N  read address, upper-half-free operand
- ram_addr_b  out  LOG_N  read address, partner operand
- ram_rdata_a  in  K  read data for addr_a
- ram_rdata_b  in  K  read data for addr_b
- drain  in  1  level; downstream has written back every butterfly it received
- out_valid  out  1  operand bundle valid
- out_ready  in  1  downstream accepts; transfer on out_valid && out_ready
- a  out  K  operand a
- b  out  K  operand b
- mod  out  K  latched modulus, stable while busy
- tw_idx  out  LOG_N  twiddle ROM index
- out_stage  out  SW  stage of bundle
- out_addr_a  out  LOG_N  writeback address for a
- out_addr_b  out  LOG_N  writeback address for b
- range_err  out  1  see Optional Feature

Behaviour:
- Reset values: busy=0, done=0, ram_rd_en=0, out_valid=0, all addresses, data, tw_idx and out_stage =0, mod=0, range_err=0. FSM goes to IDLE. Buffer and in-flight flag clear.
- Reset mid-operation: abandons the transform immediately, with no done pulse.
- FSM states: IDLE -> ISSUE -> FLUSH -> WAIT_DRAIN -> (ISSUE for next stage | DONE) -> IDLE.
- IDLE: on start, latch mod_in, set s=0 and k=0, then enter ISSUE.
- Address generation for stage s and butterfly k (0..N/2-1):
  - h = 1<<(LOG_N-1-s); g = k>>(LOG_N-1-s); o = k&(h-1).
  - addr_a = g*2h + o; addr_b = addr_a + h; tw_idx = (1<<s) + g.
  - All arithmetic is LOG_N bits and cannot overflow.
- ISSUE: assert ram_rd_en when (buffer count + in-flight) < 2, or when a buffer pop occurs this cycle. Each issue increments k.
  - The issue at k = N/2-1 moves to FLUSH.
- Read data returning one cycle after ram_rd_en is pushed into the buffer, tagged with the issue-cycle addresses, tw_idx and s.
  - The buffer never overflows because of the issue rule.
- Output side: FIFO order, head drives the outputs. out_valid = buffer not empty.
  - Outputs hold while out_valid && !out_ready.
  - Simultaneous push and pop keeps count.
  - Sustained out_ready gives 1 bundle/cycle after a 2-cycle initial latency (issue -> rdata -> registered head).
- FLUSH: wait until the buffer is empty and nothing is in flight, then enter WAIT_DRAIN.
- WAIT_DRAIN: wait for drain=1.
  - If s==LOG_N-1: go to DONE.
  - Otherwise: s++, k=0, go to ISSUE.
  - drain already high on entry is honoured in that cycle.
- DONE: pulse done=1 for one cycle; busy falls in the same cycle; return to IDLE.
- A start arriving while busy has no effect. A start arriving in the DONE cycle is also ignored.

Optional Feature:
- Macro: NTT_RANGE_CHECK_EN.
- Defined:
  - range_err is sticky; it sets when a buffer push has rdata_a >= mod or rdata_b >= mod.
  - It clears on an accepted start. Data still flows unmodified.
- Undefined: range_err is tied 0 and no comparators are built.

Decomposition:
- Shared package ntt_pkg holds:
  - fetch_state_t enum (IDLE, ISSUE, FLUSH, WAIT_DRAIN, DONE);
  - the operand bundle struct (a, b, tw_idx, stage, addr_a, addr_b);
  - N and half-N constants derived from LOG_N.
- One sub-module: ntt_fetch_skid, a 2-entry FIFO of the bundle struct exposing count, push, pop.

Test Plan:
- LOG_N=3, out_ready=1, drain=1, mod=17. Expected stage sequence:
  - stage 0: (0,4,tw1), (1,5,tw1), (2,6,tw1), (3,7,tw1);
  - stage 1: (0,2,tw2), (1,3,tw2), (4,6,tw3), (5,7,tw3);
  - stage 2: (0,1,tw4), (2,3,tw5), (4,5,tw6), (6,7,tw7);
  - done after 12 transfers, exactly one pulse.
- RAM model returns addr+100. Toggle out_ready randomly (50%). Expected: no lost or duplicated bundles, a/b equal addr+100, head held while stalled, ram_rd_en never issued with count+in-flight=2.
- drain held 0 for 20 cycles after stage 0. Expected: no stage-1 ram_rd_en until drain=1, busy stays 1.
- rst asserted mid-stage 1 with out_valid=1. Expected: out_valid=0 and busy=0 immediately; a later start restarts at stage 0 / address 0.
- start pulsed while busy. Expected: no restart, sequence unchanged.
- NTT_RANGE_CHECK_EN defined, mod=17, RAM returns 17 at address 5. Expected: range_err=1 after that push, stays set, cleared by the next start.
